mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single-port, synchronous-read data memory (`data_mem`). It lets the core data port (requester 0) and a second master (requester 1, e.g. the loader or second core) share the memory. Each access is captured, issued to the memory for one cycle and completed with an acknowledge. It sits between the masters and `data_mem` in the top level, replacing the direct core-to-memory wiring.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 10, memory word-address width.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held with the command until `mX_gnt`.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  word address.
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data; valid with a read ack, held until the next read ack to that master.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, any `req` high: arbitrate, assert the winner's `gnt`, latch the winner's id, we, addr and wdata, and go to ISSUE. No `req`: stay in IDLE.
- ISSUE: drive `mem_addr` and `mem_wdata` from the latched command. `mem_we` equals the latched we.
  - Write: pulse the owner's `ack` and go to IDLE.
  - Read: go to RESP.
- RESP: register `mem_rdata` into the owner's `rdata` and pulse its `ack`.
  - If any `req` is high, arbitrate and grant in this same cycle, then go to ISSUE (back-to-back).
  - Otherwise go to IDLE.
- `gnt` is asserted only in IDLE or RESP, and to at most one master per cycle.
- The loser of a simultaneous request keeps `req` asserted and is granted at the next arbitration point.
- `mem_we` is 0 in every state except a write ISSUE.
- `mem_addr` and `mem_wdata` hold the last latched command outside ISSUE.
- A `req` that drops before its `gnt` is a protocol violation. Behaviour is undefined; verify with an assertion.

## Timing
- Reset values (asynchronous, while `reset_n` = 0):
  - state IDLE
  - all `gnt`, `ack` and `mem_we` = 0
  - `mem_addr`, `mem_wdata`, both `rdata` = 0
  - round-robin pointer favours m0.
- Write latency: `gnt` in cycle N, `ack` and `mem_we` in cycle N+1. Memory is written at the end of N+1.
- Read latency: `gnt` in cycle N, ISSUE in N+1, `ack` and `rdata` in N+2.
- Throughput:
  - Back-to-back reads: one read every 2 cycles.
  - Writes: one write every 2 cycles, because each write returns to IDLE.
- Reset asserted mid-access:
  - The access is aborted and no `ack` is produced.
  - `mem_we` drops immediately (asynchronously).
  - A write in ISSUE may or may not be committed; masters reissue after reset.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred master. It flips to the other master after each grant.
  - With both masters requesting continuously, grants alternate m0, m1, m0, …
- `MEM_ARB_RR_EN` undefined: fixed priority, m0 always wins. m1 is granted only when `m0_req` = 0 at an arbitration point. There is no pointer register.

## Test plan
- Reset release, idle: all outputs 0, state IDLE, `mem_we` stays 0 for 10 cycles with no `req`.
- m0 writes 0xDEADBEEF to 0x010, then m0 reads 0x010:
  - write `ack` one cycle after `gnt`
  - read `ack` two cycles after `gnt` with `m0_rdata` = 0xDEADBEEF
  - `m1_rdata` unchanged.
- m0 and m1 request reads of 0x001 and 0x002 simultaneously, with RR enabled:
  - m0 granted first, m1 granted in m0's RESP cycle
  - acks 2 cycles apart, each with its own data.
- Both masters hold `req` for 8 accesses:
  - RR build: grants strictly alternate, 4 each.
  - Fixed-priority build: m1 gets 0 grants while `m0_req` stays high.
- Reset pulse while in ISSUE of an m1 read: `m1_ack` never pulses, `mem_we` = 0 at once, FSM in IDLE after release, a reissued read completes normally.
- m1 write followed immediately by an m0 read of the same address: `m0_rdata` returns m1's written value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for the single-port,
// synchronous-read data memory. Each access is granted, issued to the memory
// for one cycle and completed with a one-cycle acknowledge.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, m0 always wins (fixed priority).
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_grant;
    logic                  w_anyReq;
    logic                  w_winner;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    // No grant may be issued while the block is held in reset.
    assign w_anyReq = reset_n & (m0_req | m1_req);

`ifdef MEM_ARB_RR_EN
    logic r_ptr;

    // Preferred-master pointer: after every grant the other master is favoured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_winner;
        end
    end

    assign w_winner = (m0_req & m1_req) ? r_ptr : ~m0_req;
`else
    assign w_winner = ~m0_req;
`endif

    // State register; an asserted reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and grant decision; IDLE and RESP are the arbitration points.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_grant     = 1'b1;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = r_we ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (w_anyReq) begin
                    w_grant     = 1'b1;
                    w_nextState = ST_ISSUE;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's command; it drives the memory port until the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? m1_we    : m0_we;
            r_addr  <= w_winner ? m1_addr  : m0_addr;
            r_wdata <= w_winner ? m1_wdata : m0_wdata;
        end
    end

    // Keep each master's last read data until its next read completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_owner) begin
                r_rdata1 <= mem_rdata;
            end else begin
                r_rdata0 <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = w_grant & ~w_winner;
    assign m1_gnt    = w_grant &  w_winner;

    assign mem_we    = (r_state == ST_ISSUE) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign m0_ack    = (mem_we | (r_state == ST_RESP)) & ~r_owner;
    assign m1_ack    = (mem_we | (r_state == ST_RESP)) &  r_owner;

    // Read data is presented in the same cycle as its acknowledge.
    assign m0_rdata  = ((r_state == ST_RESP) & ~r_owner) ? mem_rdata : r_rdata0;
    assign m1_rdata  = ((r_state == ST_RESP) &  r_owner) ? mem_rdata : r_rdata1;

    // A master must keep its request up until it is granted.
    m0ReqHeld: assert property (@(posedge clk) disable iff (!reset_n)
                                (m0_req && !m0_gnt) |=> m0_req);
    m1ReqHeld: assert property (@(posedge clk) disable iff (!reset_n)
                                (m1_req && !m1_gnt) |=> m1_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level
// model of the arbiter (grant, latencies, memory contents) is compared with
// the DUT every cycle, and directed scenarios pin literal expectations.
// Honours MEM_ARB_RR_EN the same way the design does.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] memRdata = '0;

    logic [DW-1:0] memArr [0:(1<<AW)-1];
    int            cycCnt = 0;
    int            nPass  = 0;
    int            nTotal = 0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    // Cycle counter, stable when sampled on the falling edge.
    always @(posedge clk) cycCnt <= cycCnt + 1;

    // Stand-in for data_mem: synchronous write and synchronous read.
    always @(posedge clk) begin
        if (mem_we) memArr[mem_addr] <= mem_wdata;
        memRdata <= memArr[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nTotal++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        else nPass++;
    endtask

    task automatic timeoutFail(input string name);
        nTotal++;
        $display("[TB] FAIL %s: timed out waiting on DUT, required a response", name);
    endtask

    // Model state: one outstanding access, next arbitration cycle, memory image.
    int            nextArb = 0;
    bit            pendValid = 0;
    bit            pendM, pendWe;
    int            pendIssue, pendAck;
    logic [AW-1:0] pendAddr;
    logic [DW-1:0] pendWdata;
    logic [AW-1:0] expAddr  = '0;
    logic [DW-1:0] expWdata = '0;
    logic [DW-1:0] expRdata0 = '0, expRdata1 = '0;
    bit            pref = 0;
    logic [DW-1:0] refMem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            memArr[i] = '0;
            refMem[i] = '0;
        end
    end

    // Model: every access takes two cycles between arbitration points; writes
    // ack one cycle after grant, reads two; compare all outputs each cycle.
    always @(negedge clk) begin : compareProc
        bit arb, win, ackNow;
        logic [4:0] expCtrl;
        if (!reset_n) begin
            pendValid = 0;
            nextArb   = cycCnt + 1;
            expAddr   = '0;
            expWdata  = '0;
            expRdata0 = '0;
            expRdata1 = '0;
            pref      = 0;
        end
        arb = reset_n && (cycCnt >= nextArb) && (m0_req || m1_req);
`ifdef MEM_ARB_RR_EN
        win = (m0_req && m1_req) ? pref : !m0_req;
`else
        win = !m0_req;
`endif
        ackNow = pendValid && (cycCnt == pendAck);
        if (ackNow && !pendWe) begin
            if (pendM) expRdata1 = refMem[pendAddr];
            else       expRdata0 = refMem[pendAddr];
        end
        expCtrl = {arb && !win, arb && win, ackNow && !pendM, ackNow && pendM,
                   pendValid && (cycCnt == pendIssue) && pendWe};
        checkOutput("ctrl{g0,g1,a0,a1,we}", {m0_gnt, m1_gnt, m0_ack, m1_ack, mem_we}, expCtrl);
        checkOutput("memAddr", mem_addr, expAddr);
        checkOutput("memWdata", mem_wdata, expWdata);
        checkOutput("m0Rdata", m0_rdata, expRdata0);
        checkOutput("m1Rdata", m1_rdata, expRdata1);
        if (ackNow) begin
            if (pendWe) refMem[pendAddr] = pendWdata;
            pendValid = 0;
        end
        if (arb) begin
            pendValid = 1;
            pendM     = win;
            pendWe    = win ? m1_we : m0_we;
            pendAddr  = win ? m1_addr : m0_addr;
            pendWdata = win ? m1_wdata : m0_wdata;
            pendIssue = cycCnt + 1;
            pendAck   = cycCnt + (pendWe ? 1 : 2);
            nextArb   = cycCnt + 2;
            expAddr   = pendAddr;
            expWdata  = pendWdata;
            pref      = !win;
        end
    end

    // One access by master m: request, hold until grant, then wait for ack.
    task automatic applyStimulus(input bit m, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, output int gntCyc, output int ackCyc);
        gntCyc = -1;
        ackCyc = -1;
        @(posedge clk); #1;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m ? m1_gnt : m0_gnt) begin gntCyc = cycCnt; break; end
        end
        @(posedge clk); #1;
        if (m) m1_req = 0; else m0_req = 0;
        if (gntCyc < 0) begin timeoutFail("grantWait"); return; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) begin ackCyc = cycCnt; break; end
        end
        if (ackCyc < 0) timeoutFail("ackWait");
    endtask

    // Reset pulse while master m's access sits in ISSUE; no ack may follow.
    task automatic resetInIssue(input bit m, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int gntCyc, ackSeen;
        gntCyc  = -1;
        ackSeen = 0;
        @(posedge clk); #1;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m ? m1_gnt : m0_gnt) begin gntCyc = cycCnt; break; end
        end
        @(posedge clk); #1;
        if (m) m1_req = 0; else m0_req = 0;
        if (gntCyc < 0) begin timeoutFail("rstGrantWait"); return; end
        checkOutput("issueMemWe", mem_we, we);
        #1 reset_n = 0;
        #1 checkOutput("rstMemWeAsync", mem_we, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) ackSeen++;
        end
        checkOutput("rstNoAck", ackSeen, 0);
        @(posedge clk); #1 reset_n = 1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at 100000ns, required to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios in order; the compare process checks every cycle.
    initial begin : mainSeq
        int g, a, g0c, a0c, g1c, a1c, weSeen;
        int c0, c1, tot, lastW, alt, gi;
        bit d0, d1, p0, p1;
        reset_n = 0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Idle after reset: nothing driven toward the memory.
        weSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            weSeen = weSeen | int'(mem_we);
        end
        checkOutput("idleMemWe", weSeen, 0);

        // m0 write then read back of the same word.
        applyStimulus(0, 1, 10'h010, 32'hDEADBEEF, g, a);
        checkOutput("wrLatency", a - g, 1);
        applyStimulus(0, 0, 10'h010, 32'h0, g, a);
        checkOutput("rdLatency", a - g, 2);
        checkOutput("rdData", m0_rdata, 32'hDEADBEEF);
        checkOutput("m1Untouched", m1_rdata, 32'h0);

        // Preload two words, then simultaneous reads.
        applyStimulus(0, 1, 10'h001, 32'h11111111, g, a);
        applyStimulus(1, 1, 10'h002, 32'h22222222, g, a);
        fork
            applyStimulus(0, 0, 10'h001, 32'h0, g0c, a0c);
            applyStimulus(1, 0, 10'h002, 32'h0, g1c, a1c);
        join
        checkOutput("simGntGap", g1c - g0c, 2);
        checkOutput("simAckGap", a1c - a0c, 2);
        checkOutput("simM0Data", m0_rdata, 32'h11111111);
        checkOutput("simM1Data", m1_rdata, 32'h22222222);

        // Both masters hold requests; count the first eight grants.
        c0 = 0; c1 = 0; tot = 0; lastW = -1; alt = 1;
        d0 = 0; d1 = 0; p0 = 0; p1 = 0;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 10'h001;
        m1_req = 1; m1_we = 0; m1_addr = 10'h002;
        for (int i = 0; i < 200 && !(d0 && d1); i++) begin
            @(negedge clk);
            gi = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
            if (gi >= 0) begin
                if (tot < 8) begin
                    if (gi == 0) c0++; else c1++;
                    if (lastW == gi) alt = 0;
                    lastW = gi;
                end
                tot++;
                if (tot >= 8) begin
                    if (gi == 0) p0 = 1; else p1 = 1;
                end
            end
            @(posedge clk); #1;
            if (p0 && !d0) begin m0_req = 0; d0 = 1; end
            if (p1 && !d1) begin m1_req = 0; d1 = 1; end
        end
        if (!(d0 && d1)) timeoutFail("contention");
        repeat (4) @(posedge clk);
`ifdef MEM_ARB_RR_EN
        checkOutput("rrM0Grants", c0, 4);
        checkOutput("rrM1Grants", c1, 4);
        checkOutput("rrAlternate", alt, 1);
`else
        checkOutput("fpM0Grants", c0, 8);
        checkOutput("fpM1Grants", c1, 0);
`endif

        // Reset during an m1 read in ISSUE, then reissue it.
        resetInIssue(1, 0, 10'h002, 32'h0);
        checkOutput("postRstM1Data", m1_rdata, 32'h0);
        applyStimulus(1, 0, 10'h002, 32'h0, g, a);
        checkOutput("reissueLatency", a - g, 2);
        checkOutput("reissueData", m1_rdata, 32'h22222222);

        // Reset during a write in ISSUE: write enable must fall at once.
        resetInIssue(0, 1, 10'h020, 32'hBAD0BAD0);

        // m1 write followed immediately by an m0 read of the same address.
        fork
            applyStimulus(1, 1, 10'h030, 32'hCAFEF00D, g1c, a1c);
            begin
                @(posedge clk);
                applyStimulus(0, 0, 10'h030, 32'h0, g0c, a0c);
            end
        join
        checkOutput("rawGntGap", g0c - g1c, 2);
        checkOutput("rawData", m0_rdata, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
